sum_batch_accumulator: RTL and testbench

- Downstream consumer of the 4-bit registered adder stage.
- Takes each adder result ({Overflow,Sum}, a 5-bit unsigned true sum) qualified by a valid strobe.
- Accumulates BATCH results into a saturating running total and counts overflow events.
- Presents the batch result on a valid/ready handshake to the next stage (display/logging).

---
 rtl/sum_batch_accumulator.sv | 169 ++++++++++++++++
 tb/tb_sum_batch_accumulator.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sum_batch_accumulator.sv
// Purpose : accumulates BATCH adder results ({Overflow,Sum}) into a saturating total and counts overflows.
// Latency : Out_Valid rises one cycle after the BATCH-th accepted In_Valid sample.
// Backpres: the batch result holds in DONE until Out_Valid & Out_Ready; samples outside ACCUM are dropped.
//
// Ports:
//   Clk, Rst        - rising-edge clock, synchronous active-high reset
//   Start           - begin a batch (from IDLE, or from DONE on the handshake cycle)
//   In_Valid, Sum, Overflow - upstream adder result, 5-bit unsigned {Overflow,Sum}
//   Out_Valid, Out_Ready    - batch result handshake
//   Total, Ovf_Count, Sat   - saturating total, overflow-sample count (max 15), sticky clip flag
//   Busy            - high while accumulating
//   Drop_Count      - only with SUM_BATCH_ACC_DROP_CNT_EN defined: samples seen outside ACCUM (max 255)
module sum_batch_accumulator #(
    parameter int DATA_W = 4,
    parameter int ACC_W  = 8,
    parameter int BATCH  = 4
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Start,
    input  logic              In_Valid,
    input  logic [DATA_W-1:0] Sum,
    input  logic              Overflow,
    input  logic              Out_Ready,
    output logic              Out_Valid,
    output logic [ACC_W-1:0]  Total,
    output logic [3:0]        Ovf_Count,
    output logic              Sat,
    output logic              Busy
`ifdef SUM_BATCH_ACC_DROP_CNT_EN
    ,
    output logic [7:0]        Drop_Count
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    // Counter value at which the incoming sample is the last one of the batch.
    localparam logic [7:0]       LAST_IDX = 8'(BATCH - 1);
    localparam logic [ACC_W-1:0] ACC_MAX  = '1;

    logic [1:0]       state_q, state_d;
    logic [ACC_W-1:0] total_q, total_d;
    logic [3:0]       ovf_q, ovf_d;
    logic             sat_q, sat_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             out_vld_q, out_vld_d;
    logic             busy_q, busy_d;

    // One spare bit above the total catches the carry that signals clipping.
    logic [ACC_W:0] sample_ext;
    logic [ACC_W:0] sum_full;
    logic           clipped;
    logic           handshake;

    assign sample_ext = (ACC_W + 1)'({Overflow, Sum});
    assign sum_full   = {1'b0, total_q} + sample_ext;
    assign clipped    = sum_full[ACC_W];
    assign handshake  = out_vld_q & Out_Ready;

    always_comb begin
        state_d   = state_q;
        total_d   = total_q;
        ovf_d     = ovf_q;
        sat_d     = sat_q;
        cnt_d     = cnt_q;
        out_vld_d = out_vld_q;
        busy_d    = busy_q;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    state_d = S_ACCUM;
                    total_d = '0;
                    ovf_d   = '0;
                    sat_d   = 1'b0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            S_ACCUM: begin
                if (In_Valid) begin
                    total_d = clipped ? ACC_MAX : sum_full[ACC_W-1:0];
                    sat_d   = sat_q | clipped;
                    if (Overflow && (ovf_q != 4'hF)) begin
                        ovf_d = ovf_q + 4'd1;
                    end
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == LAST_IDX) begin
                        state_d   = S_DONE;
                        out_vld_d = 1'b1;
                        busy_d    = 1'b0;
                    end
                end
            end
            S_DONE: begin
                if (handshake) begin
                    out_vld_d = 1'b0;
                    if (Start) begin
                        // Back-to-back batch: skip IDLE entirely.
                        state_d = S_ACCUM;
                        total_d = '0;
                        ovf_d   = '0;
                        sat_d   = 1'b0;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d   = S_IDLE;
                out_vld_d = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= S_IDLE;
            total_q   <= '0;
            ovf_q     <= '0;
            sat_q     <= 1'b0;
            cnt_q     <= '0;
            out_vld_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            total_q   <= total_d;
            ovf_q     <= ovf_d;
            sat_q     <= sat_d;
            cnt_q     <= cnt_d;
            out_vld_q <= out_vld_d;
            busy_q    <= busy_d;
        end
    end

    assign Out_Valid = out_vld_q;
    assign Total     = total_q;
    assign Ovf_Count = ovf_q;
    assign Sat       = sat_q;
    assign Busy      = busy_q;

`ifdef SUM_BATCH_ACC_DROP_CNT_EN
    // Persists across batches; only Rst clears it.
    logic [7:0] drop_q, drop_d;

    always_comb begin
        drop_d = drop_q;
        if (In_Valid && (state_q != S_ACCUM) && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign Drop_Count = drop_q;
`endif

endmodule

// File: tb/tb_sum_batch_accumulator.sv
// Bench for sum_batch_accumulator: drives a default instance (ACC_W=8) and a narrow
// instance (ACC_W=6) with identical stimulus; a scoreboard per instance holds the
// expected batch results, computed from the list of samples in each batch.
module tb_sum_batch_accumulator;

    localparam int BATCH = 4;

    typedef struct {
        int total;
        int ovf;
        int sat;
    } exp_t;

    logic       Clk;
    logic       Rst;
    logic       Start;
    logic       In_Valid;
    logic [3:0] Sum;
    logic       Overflow;
    logic       Out_Ready;

    logic       Out_Valid8, Sat8, Busy8;
    logic [7:0] Total8;
    logic [3:0] Ovf8;
    logic       Out_Valid6, Sat6, Busy6;
    logic [5:0] Total6;
    logic [3:0] Ovf6;
`ifdef SUM_BATCH_ACC_DROP_CNT_EN
    logic [7:0] Drop8, Drop6;
`endif

    int checks = 0;
    int errors = 0;
    int exp_drop = 0;

    exp_t       q8[$];
    exp_t       q6[$];
    logic [4:0] cur[$];

    sum_batch_accumulator #(.DATA_W(4), .ACC_W(8), .BATCH(BATCH)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .In_Valid(In_Valid), .Sum(Sum),
        .Overflow(Overflow), .Out_Ready(Out_Ready), .Out_Valid(Out_Valid8),
        .Total(Total8), .Ovf_Count(Ovf8), .Sat(Sat8), .Busy(Busy8)
`ifdef SUM_BATCH_ACC_DROP_CNT_EN
        , .Drop_Count(Drop8)
`endif
    );

    sum_batch_accumulator #(.DATA_W(4), .ACC_W(6), .BATCH(BATCH)) dut6 (
        .Clk(Clk), .Rst(Rst), .Start(Start), .In_Valid(In_Valid), .Sum(Sum),
        .Overflow(Overflow), .Out_Ready(Out_Ready), .Out_Valid(Out_Valid6),
        .Total(Total6), .Ovf_Count(Ovf6), .Sat(Sat6), .Busy(Busy6)
`ifdef SUM_BATCH_ACC_DROP_CNT_EN
        , .Drop_Count(Drop6)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: saturating sum of a batch equals min(plain sum, max) since samples are non-negative.
    task automatic push_exp();
        int   s;
        int   o;
        exp_t e;
        s = 0;
        o = 0;
        foreach (cur[i]) begin
            s += int'(cur[i]);
            if (cur[i][4]) o++;
        end
        e.ovf   = (o > 15) ? 15 : o;
        e.total = (s > 255) ? 255 : s;
        e.sat   = (s > 255) ? 1 : 0;
        q8.push_back(e);
        e.total = (s > 63) ? 63 : s;
        e.sat   = (s > 63) ? 1 : 0;
        q6.push_back(e);
        cur.delete();
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_start();
        Start = 1'b1;
        tick();
        Start = 1'b0;
        cur.delete();
    endtask

    task automatic send(input logic [4:0] v);
        In_Valid = 1'b1;
        {Overflow, Sum} = v;
        tick();
        In_Valid = 1'b0;
        cur.push_back(v);
        if (cur.size() == BATCH) push_exp();
    endtask

    // Only used while the DUT is outside ACCUM.
    task automatic drop_pulse();
        In_Valid = 1'b1;
        {Overflow, Sum} = 5'($urandom);
        tick();
        In_Valid = 1'b0;
        if (exp_drop < 255) exp_drop++;
    endtask

    task automatic handshake(input bit nxt);
        Out_Ready = 1'b1;
        Start     = nxt;
        tick();
        Out_Ready = 1'b0;
        Start     = 1'b0;
        if (nxt) cur.delete();
    endtask

    task automatic chk_drop(input string nm);
`ifdef SUM_BATCH_ACC_DROP_CNT_EN
        chk({nm, "_drop8"}, int'(Drop8), exp_drop);
        chk({nm, "_drop6"}, int'(Drop6), exp_drop);
`endif
    endtask

    task automatic chk_quiet(input string nm, input int total8);
        chk({nm, "_out_valid"}, int'(Out_Valid8), 0);
        chk({nm, "_busy"}, int'(Busy8), 0);
        chk({nm, "_total"}, int'(Total8), total8);
    endtask

    // Scoreboard monitor: every cycle a result is presented it must match the head entry.
    always @(negedge Clk) begin
        if (!Rst) begin
            if (Out_Valid8) begin
                if (q8.size() == 0) begin
                    chk("sb8_unexpected_valid", 1, 0);
                end else begin
                    chk("sb8_total", int'(Total8), q8[0].total);
                    chk("sb8_ovf", int'(Ovf8), q8[0].ovf);
                    chk("sb8_sat", int'(Sat8), q8[0].sat);
                    if (Out_Ready) void'(q8.pop_front());
                end
            end
            if (Out_Valid6) begin
                if (q6.size() == 0) begin
                    chk("sb6_unexpected_valid", 1, 0);
                end else begin
                    chk("sb6_total", int'(Total6), q6[0].total);
                    chk("sb6_ovf", int'(Ovf6), q6[0].ovf);
                    chk("sb6_sat", int'(Sat6), q6[0].sat);
                    if (Out_Ready) void'(q6.pop_front());
                end
            end
        end
    end

    initial begin
        bit in_accum;
        bit bb;
        Rst = 1'b1; Start = 1'b0; In_Valid = 1'b0; Sum = '0; Overflow = 1'b0; Out_Ready = 1'b0;
        repeat (2) tick();
        Rst = 1'b0;
        @(negedge Clk);
        chk_quiet("reset", 0);
        chk("reset_ovf", int'(Ovf8), 0);
        chk("reset_sat", int'(Sat8), 0);
        chk_drop("reset");

        // Samples in IDLE are ignored.
        repeat (3) drop_pulse();
        @(negedge Clk);
        chk_quiet("idle_ignore", 0);
        chk_drop("idle_drops");

        // Consecutive batch: 3,5,{1,2},0 -> 26, one overflow.
        do_start();
        @(negedge Clk);
        chk("start_busy", int'(Busy8), 1);
        send(5'd3); send(5'd5); send(5'b1_0010);
        @(negedge Clk);
        chk("pre_last_out_valid", int'(Out_Valid8), 0);
        send(5'd0);
        @(negedge Clk);
        chk("latency_out_valid", int'(Out_Valid8), 1);
        chk("latency_busy", int'(Busy8), 0);
        chk("batch1_total", int'(Total8), 26);
        handshake(1'b0);
        @(negedge Clk);
        chk_quiet("after_hs", 26);
        chk("after_hs_ovf", int'(Ovf8), 1);

        // Same batch with 2-cycle gaps, then a stalled DONE with ignored samples.
        do_start();
        send(5'd3); repeat (2) tick();
        send(5'd5); repeat (2) tick();
        send(5'b1_0010); repeat (2) tick();
        send(5'd0);
        for (int i = 0; i < 5; i++) begin
            if (i == 1 || i == 3) drop_pulse(); else tick();
            chk("done_hold_valid", int'(Out_Valid8), 1);
            chk("done_hold_total", int'(Total8), 26);
        end
        chk_drop("done_drops");
        handshake(1'b0);
        do_start();
        @(negedge Clk);
        chk_drop("start_keeps_drop");

        // Saturation on the narrow instance: 31 x4 -> 63 with Sat, 124 on the wide one.
        repeat (4) send(5'd31);
        @(negedge Clk);
        chk("sat6_total", int'(Total6), 63);
        chk("sat6_sat", int'(Sat6), 1);
        chk("sat6_ovf", int'(Ovf6), 4);
        chk("wide_total", int'(Total8), 124);
        handshake(1'b1);
        @(negedge Clk);
        chk("b2b_busy", int'(Busy8), 1);
        chk("b2b_total", int'(Total8), 0);
        chk("b2b_out_valid", int'(Out_Valid8), 0);
        repeat (4) send(5'd1);
        @(negedge Clk);
        chk("b2b_second_total", int'(Total8), 4);
        handshake(1'b0);

        // Reset in the middle of a batch discards it.
        do_start();
        send(5'd7); send(5'd9);
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        cur.delete();
        exp_drop = 0;
        @(negedge Clk);
        chk_quiet("midrst", 0);
        chk("midrst_ovf", int'(Ovf8), 0);
        chk("midrst_sat6", int'(Sat6), 0);
        chk_drop("midrst");
        repeat (2) drop_pulse();
        @(negedge Clk);
        chk_quiet("midrst_ignore", 0);
        chk_drop("midrst_drops");

        // Randomized batches with gaps, stalls, ignored samples and back-to-back starts.
        in_accum = 1'b0;
        for (int b = 0; b < 25; b++) begin
            if (!in_accum) begin
                repeat ($urandom_range(0, 2)) drop_pulse();
                do_start();
            end
            for (int s = 0; s < BATCH; s++) begin
                repeat ($urandom_range(0, 2)) tick();
                send(5'($urandom_range(0, 31)));
            end
            repeat ($urandom_range(0, 3)) begin
                if ($urandom_range(0, 1) == 1) drop_pulse(); else tick();
            end
            bb = (b == 24) ? 1'b0 : 1'($urandom_range(0, 1));
            handshake(bb);
            in_accum = bb;
        end

        repeat (3) tick();
        @(negedge Clk);
        chk("sb8_drained", q8.size(), 0);
        chk("sb6_drained", q6.size(), 0);
        chk_drop("final");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
